// File: rtl/spike_encoder.sv
// Rate-coding spike encoder: integrate-and-fire with subtractive reset over a latched window.
// Optional per-channel spike counters are built when SPIKE_ENCODER_COUNT_EN is defined.
module spike_encoder #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned TIMER_WIDTH  = 5,
  parameter int unsigned NUM_CHANNELS = 3
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [TIMER_WIDTH-1:0]              accumulate_interval,
  input  logic [DATA_WIDTH-1:0]               threshold,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  in_values,
  output logic [NUM_CHANNELS-1:0]             spikes,
  output logic                                spike_valid,
  output logic                                window_done,
  output logic [NUM_CHANNELS*TIMER_WIDTH-1:0] spike_count
);

  typedef enum logic [0:0] {StIdle, StEncode} state_e;

  state_e                                  state_q, state_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      values_q, values_d;
  logic [DATA_WIDTH-1:0]                   thresh_q, thresh_d;
  logic [TIMER_WIDTH-1:0]                  len_q, len_d;
  logic [TIMER_WIDTH-1:0]                  timer_q, timer_d;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
  logic [NUM_CHANNELS-1:0]                 spikes_q, spikes_d;
  logic                                    spike_valid_q, spike_valid_d;
  logic                                    window_done_q, window_done_d;

  logic [NUM_CHANNELS-1:0][DATA_WIDTH:0]   acc_sum, residual;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] step_acc;
  logic [NUM_CHANNELS-1:0]                 step_spk;
  logic                                    accept, encoding, last_step;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign encoding  = (state_q == StEncode);
  assign last_step = encoding && (timer_q == len_q - 1'b1);

  // Accumulator never exceeds threshold-1, so DATA_WIDTH+1 bits cannot overflow.
  always_comb begin
    acc_sum  = '0;
    residual = '0;
    step_acc = '0;
    step_spk = '0;
    for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
      acc_sum[ch]  = {1'b0, acc_q[ch]} + {1'b0, values_q[ch*DATA_WIDTH +: DATA_WIDTH]};
      residual[ch] = acc_sum[ch] - {1'b0, thresh_q};
      if (thresh_q == '0) begin
        step_spk[ch] = |values_q[ch*DATA_WIDTH +: DATA_WIDTH];
        step_acc[ch] = '0;
      end else if (acc_sum[ch] >= {1'b0, thresh_q}) begin
        step_spk[ch] = 1'b1;
        step_acc[ch] = (residual[ch] >= {1'b0, thresh_q}) ? thresh_q - 1'b1
                                                          : residual[ch][DATA_WIDTH-1:0];
      end else begin
        step_acc[ch] = acc_sum[ch][DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    values_d      = values_q;
    thresh_d      = thresh_q;
    len_d         = len_q;
    timer_d       = timer_q;
    acc_d         = acc_q;
    spikes_d      = '0;
    spike_valid_d = 1'b0;
    window_done_d = 1'b0;
    if (accept) begin
      values_d = in_values;
      thresh_d = threshold;
      len_d    = (accumulate_interval == '0) ? TIMER_WIDTH'(1) : accumulate_interval;
      timer_d  = '0;
      acc_d    = '0;
      state_d  = StEncode;
    end else if (encoding) begin
      acc_d         = step_acc;
      spikes_d      = step_spk;
      spike_valid_d = 1'b1;
      timer_d       = timer_q + 1'b1;
      if (last_step) begin
        window_done_d = 1'b1;
        state_d       = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      values_q      <= '0;
      thresh_q      <= '0;
      len_q         <= '0;
      timer_q       <= '0;
      acc_q         <= '0;
      spikes_q      <= '0;
      spike_valid_q <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      values_q      <= values_d;
      thresh_q      <= thresh_d;
      len_q         <= len_d;
      timer_q       <= timer_d;
      acc_q         <= acc_d;
      spikes_q      <= spikes_d;
      spike_valid_q <= spike_valid_d;
      window_done_q <= window_done_d;
    end
  end

  assign spikes      = spikes_q;
  assign spike_valid = spike_valid_q;
  assign window_done = window_done_q;

`ifdef SPIKE_ENCODER_COUNT_EN
  logic [NUM_CHANNELS-1:0][TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CHANNELS-1:0][TIMER_WIDTH-1:0] spike_count_q, spike_count_d;

  // Published total includes the last step, so it is taken from the next-state counts.
  always_comb begin
    cnt_d         = cnt_q;
    spike_count_d = spike_count_q;
    if (accept) begin
      cnt_d = '0;
    end else if (encoding) begin
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
        cnt_d[ch] = cnt_q[ch] + {{(TIMER_WIDTH-1){1'b0}}, step_spk[ch]};
      end
      if (last_step) begin
        spike_count_d = cnt_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q         <= '0;
      spike_count_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign spike_count = spike_count_q;
`else
  assign spike_count = '0;
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: directed windows plus randomized windows checked
// against an integer integrate-and-fire reference model.
module tb_spike_encoder;
  localparam int DW = 16;
  localparam int TW = 5;
  localparam int NC = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic [TW-1:0]     accumulate_interval;
  logic [DW-1:0]     threshold;
  logic              in_valid;
  logic              in_ready;
  logic [NC*DW-1:0]  in_values;
  logic [NC-1:0]     spikes;
  logic              spike_valid;
  logic              window_done;
  logic [NC*TW-1:0]  spike_count;

  always #5 clk = ~clk;

  spike_encoder #(
    .DATA_WIDTH  (DW),
    .TIMER_WIDTH (TW),
    .NUM_CHANNELS(NC)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .accumulate_interval(accumulate_interval),
    .threshold          (threshold),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_values          (in_values),
    .spikes             (spikes),
    .spike_valid        (spike_valid),
    .window_done        (window_done),
    .spike_count        (spike_count)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [NC-1:0] exp_spk [32];
  int          exp_cnt [NC];
  logic [NC*TW-1:0] held_count = '0;

  // Reference: each channel integrates its value; a spike removes one threshold worth of
  // charge, and leftover charge is capped just below one threshold.
  task automatic model(input logic [NC*DW-1:0] vals, input int thr, input int len);
    for (int ch = 0; ch < NC; ch++) begin
      int r = 0;
      int v = int'(vals[ch*DW +: DW]);
      exp_cnt[ch] = 0;
      for (int s = 0; s < 32; s++) begin
        bit sp = 1'b0;
        if (s < len) begin
          if (thr == 0) begin
            sp = (v != 0);
          end else begin
            r = r + v;
            if (r >= thr) begin
              sp = 1'b1;
              r  = r - thr;
              if (r > thr - 1) r = thr - 1;
            end
          end
        end
        exp_spk[s][ch] = sp;
        exp_cnt[ch] += int'(sp);
      end
    end
  endtask

  function automatic logic [NC*TW-1:0] cnt_vec();
    logic [NC*TW-1:0] r = '0;
`ifdef SPIKE_ENCODER_COUNT_EN
    for (int ch = 0; ch < NC; ch++) r[ch*TW +: TW] = exp_cnt[ch][TW-1:0];
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_tests++;
    if (in_ready !== 1'b1 || spikes !== '0 || spike_valid !== 1'b0 || window_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b spikes=%b sv=%b wd=%b want 1 000 0 0",
               in_ready, spikes, spike_valid, window_done);
    end
    n_tests++;
    if (spike_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %h want 0", spike_count);
    end
    rstn = 1'b1;
    held_count = '0;
    tick();
  endtask

  task automatic test_window(input string name, input logic [NC*DW-1:0] vals,
                             input logic [DW-1:0] thr, input logic [TW-1:0] ai);
    int len = (ai == 0) ? 1 : int'(ai);
    model(vals, int'(thr), len);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready);
    end
    in_values = vals;
    threshold = thr;
    accumulate_interval = ai;
    in_valid = 1'b1;
    tick();
    // Scramble inputs: the latched copy must be used for the whole window.
    in_valid = 1'b0;
    in_values = {$urandom, $urandom};
    threshold = DW'($urandom);
    accumulate_interval = TW'($urandom);
    n_tests++;
    if (in_ready !== 1'b0 || spike_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_accept: got ready=%b sv=%b want 0 0", name, in_ready, spike_valid);
    end
    for (int s = 1; s <= len; s++) begin
      tick();
      n_tests++;
      if (spikes !== exp_spk[s-1] || spike_valid !== 1'b1 || window_done !== (s == len) ||
          in_ready !== (s == len)) begin
        n_fail++;
        $display("FAIL %s step %0d: got spikes=%b sv=%b wd=%b rdy=%b want %b 1 %b %b", name, s,
                 spikes, spike_valid, window_done, in_ready, exp_spk[s-1], s == len, s == len);
      end
      n_tests++;
      if (spike_count !== ((s == len) ? cnt_vec() : held_count)) begin
        n_fail++;
        $display("FAIL %s count step %0d: got %h want %h", name, s, spike_count,
                 (s == len) ? cnt_vec() : held_count);
      end
    end
    held_count = cnt_vec();
    tick();
    n_tests++;
    if (spike_valid !== 1'b0 || window_done !== 1'b0 || spike_count !== held_count) begin
      n_fail++;
      $display("FAIL %s after_window: got sv=%b wd=%b cnt=%h want 0 0 %h", name, spike_valid,
               window_done, spike_count, held_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [NC*DW-1:0] va = {16'd20, 16'd7, 16'd16};
    logic [NC*DW-1:0] vb = {16'd3, 16'd40, 16'd0};
    model(va, 16, 4);
    in_values = va;
    threshold = 16'd16;
    accumulate_interval = 5'd4;
    in_valid = 1'b1;
    tick();
    in_values = vb;
    for (int s = 1; s <= 4; s++) begin
      tick();
      n_tests++;
      if (spikes !== exp_spk[s-1] || spike_valid !== 1'b1 || window_done !== (s == 4)) begin
        n_fail++;
        $display("FAIL b2b first step %0d: got spikes=%b sv=%b wd=%b want %b 1 %b", s, spikes,
                 spike_valid, window_done, exp_spk[s-1], s == 4);
      end
    end
    n_tests++;
    if (spike_count !== cnt_vec()) begin
      n_fail++;
      $display("FAIL b2b first count: got %h want %h", spike_count, cnt_vec());
    end
    held_count = cnt_vec();
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (spike_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b bubble: got sv=%b rdy=%b want 0 0", spike_valid, in_ready);
    end
    model(vb, 16, 4);
    for (int s = 1; s <= 4; s++) begin
      tick();
      n_tests++;
      if (spikes !== exp_spk[s-1] || spike_valid !== 1'b1 || window_done !== (s == 4)) begin
        n_fail++;
        $display("FAIL b2b second step %0d: got spikes=%b sv=%b wd=%b want %b 1 %b", s, spikes,
                 spike_valid, window_done, exp_spk[s-1], s == 4);
      end
    end
    held_count = cnt_vec();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [NC*DW-1:0] v = {16'd9, 16'd30, 16'd5};
    model(v, 10, 8);
    in_values = v;
    threshold = 16'd10;
    accumulate_interval = 5'd8;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      tick();
      n_tests++;
      if (spikes !== exp_spk[s-1] || spike_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got spikes=%b sv=%b want %b 1", s, spikes,
                 spike_valid, exp_spk[s-1]);
      end
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_tests++;
    if (spikes !== '0 || spike_valid !== 1'b0 || in_ready !== 1'b1 || window_done !== 1'b0 ||
        spike_count !== '0) begin
      n_fail++;
      $display("FAIL reset_mid flush: got spikes=%b sv=%b rdy=%b wd=%b cnt=%h want 0 0 1 0 0",
               spikes, spike_valid, in_ready, window_done, spike_count);
    end
    held_count = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if (spike_valid !== 1'b0 || window_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid late cycle %0d: got sv=%b wd=%b want 0 0", k, spike_valid,
                 window_done);
      end
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 12; w++) begin
      logic [NC*DW-1:0] v;
      logic [DW-1:0]    thr;
      thr = ($urandom_range(0, 4) == 0) ? DW'($urandom_range(0, 65535))
                                        : DW'($urandom_range(1, 40));
      for (int ch = 0; ch < NC; ch++) begin
        v[ch*DW +: DW] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 65535))
                                                     : DW'($urandom_range(0, 3 * int'(thr) + 1));
      end
      test_window("random", v, thr, TW'($urandom_range(0, 31)));
      for (int k = $urandom_range(0, 2); k > 0; k--) tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    in_values = '0;
    threshold = '0;
    accumulate_interval = '0;
    test_reset();
    test_window("basic", {16'd16, 16'd8, 16'd0}, 16'd16, 5'd8);
    test_window("clamp", {16'd1, 16'd15, 16'd40}, 16'd16, 5'd31);
    test_window("interval_zero", {16'd0, 16'd0, 16'd16}, 16'd16, 5'd0);
    test_window("thresh_zero", {16'd65535, 16'd5, 16'd0}, 16'd0, 5'd4);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
